// File: rtl/ff_op_sched.sv
// ff_op_sched: round-robin scheduler serialising LOAD/CLEAR/PRESET ops onto one shared async clear/preset flop bank.
// Define FF_OP_SCHED_PRIO_EN to let requester 0 win every arbitration it takes part in.
module ff_op_sched #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 2,
  parameter int REC_CYC   = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        op,
  input  logic [WIDTH*NREQ-1:0]    d,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic [WIDTH-1:0]         bank_d,
  output logic                     bank_en,
  output logic                     bank_clr,
  output logic                     bank_pre
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(PULSE_CYC + REC_CYC + 1);
  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_HOLD, S_RECOVER, S_DONE} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gnt;
  logic [1:0]        r_op;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_ack;
  logic              r_err;
  logic              r_busy;
  logic [WIDTH-1:0]  r_bank_d;
  logic              r_bank_en;
  logic              r_bank_clr;
  logic              r_bank_pre;

  logic              w_any;
  logic [IW-1:0]     w_win;
  logic [IW-1:0]     w_nxt;
  int                w_idx;
  logic [1:0]        w_op;
  logic [WIDTH-1:0]  w_dat;
  logic [NREQ-1:0]   w_gnt_oh;
  logic              w_is_ctl;
  logic              w_pulse_end;

  // Walk downward so the candidate closest to ptr (upward, wrapping) is assigned last and wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = (int'(r_ptr) + i) % NREQ;
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_win = IW'(w_idx);
      end
    end
`ifdef FF_OP_SCHED_PRIO_EN
    if (req[0]) begin
      w_any = 1'b1;
      w_win = '0;
    end
`else
`endif
  end

  assign w_nxt       = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign w_op        = op[2*int'(w_win) +: 2];
  assign w_dat       = d[WIDTH*int'(w_win) +: WIDTH];
  assign w_gnt_oh    = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
  assign w_is_ctl    = (r_op == OP_CLEAR) || (r_op == OP_PRESET);
  assign w_pulse_end = (r_state == S_ISSUE && w_is_ctl && PULSE_CYC == 1) ||
                       (r_state == S_HOLD && r_cnt == '0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_op       <= OP_LOAD;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_bank_d   <= '0;
      r_bank_en  <= 1'b0;
      r_bank_clr <= 1'b0;
      r_bank_pre <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gnt   <= w_win;
          r_ptr   <= w_nxt;
          r_op    <= w_op;
          r_busy  <= 1'b1;
          r_state <= S_ISSUE;
          case (w_op)
            OP_LOAD: begin
              r_bank_en <= 1'b1;
              r_bank_d  <= w_dat;
            end
            OP_CLEAR:  r_bank_clr <= 1'b1;
            OP_PRESET: r_bank_pre <= 1'b1;
            default:   ;
          endcase
        end
        S_ISSUE: begin
          if (w_is_ctl) begin
            if (PULSE_CYC > 1) begin
              r_cnt   <= CW'(PULSE_CYC - 2);
              r_state <= S_HOLD;
            end
          end else begin
            r_bank_en <= 1'b0;
            r_err     <= (r_op == 2'b11);
            r_ack     <= w_gnt_oh;
            r_state   <= S_DONE;
          end
        end
        S_HOLD: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        S_RECOVER: begin
          if (r_cnt == '0) begin
            r_ack   <= w_gnt_oh;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Shared exit from the clear/preset pulse, reached from ISSUE or HOLD.
      if (w_pulse_end) begin
        r_bank_clr <= 1'b0;
        r_bank_pre <= 1'b0;
        if (REC_CYC == 0) begin
          r_ack   <= w_gnt_oh;
          r_state <= S_DONE;
        end else begin
          r_cnt   <= CW'(REC_CYC - 1);
          r_state <= S_RECOVER;
        end
      end
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign busy     = r_busy;
  assign gnt_id   = r_gnt;
  assign bank_d   = r_bank_d;
  assign bank_en  = r_bank_en;
  assign bank_clr = r_bank_clr;
  assign bank_pre = r_bank_pre;
endmodule

// File: tb/tb_ff_op_sched.sv
// Directed bench for ff_op_sched at default parameters (NREQ=4, WIDTH=8, PULSE_CYC=2, REC_CYC=1).
module tb_ff_op_sched;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  op  = '0;
  logic [31:0] d   = '0;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic [1:0]  gnt_id;
  logic [7:0]  bank_d;
  logic        bank_en;
  logic        bank_clr;
  logic        bank_pre;

  int n_cmp = 0;
  int n_bad = 0;

  ff_op_sched dut (
    .clk(clk), .clr(clr), .req(req), .op(op), .d(d),
    .ack(ack), .err(err), .busy(busy), .gnt_id(gnt_id),
    .bank_d(bank_d), .bank_en(bank_en), .bank_clr(bank_clr), .bank_pre(bank_pre)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq[5];
    logic [3:0] exp_seq[5];
    int         na;
    int         ovl;
    int         stray;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_ctl", {err, busy, bank_en, bank_clr, bank_pre}, 0);
    chk("rst_gnt_d", {gnt_id, bank_d}, 0);
    clr = 1'b1;
    @(negedge clk);

    // LOAD from requester 2
    req = 4'b0100; op = 8'h00; d = 32'h00A5_0000;
    @(negedge clk);
    req = '0;
    chk("load_en", bank_en, 1);
    chk("load_d", bank_d, 8'hA5);
    chk("load_gnt", gnt_id, 2);
    chk("load_busy", busy, 1);
    chk("load_nocp", {bank_clr, bank_pre}, 0);
    @(negedge clk);
    chk("load_ack", ack, 4'b0100);
    chk("load_err", err, 0);
    chk("load_en_off", bank_en, 0);
    @(negedge clk);
    chk("load_idle", {busy, ack}, 0);

    // CLEAR from requester 1: clr T+1..T+2, recover T+3, ack T+4
    req = 4'b0010; op = 8'b0000_0100;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      chk($sformatf("clr_pin_c%0d", k), bank_clr, (k <= 2) ? 1 : 0);
      chk($sformatf("clr_ack_c%0d", k), ack, (k == 4) ? 4'b0010 : 4'b0000);
      chk($sformatf("clr_busy_c%0d", k), busy, (k <= 4) ? 1 : 0);
    end

    // Illegal op from requester 3
    req = 4'b1000; op = 8'hC0;
    @(negedge clk);
    req = '0;
    chk("ill_ctl_c1", {bank_en, bank_clr, bank_pre}, 0);
    chk("ill_busy", busy, 1);
    @(negedge clk);
    chk("ill_ack", ack, 4'b1000);
    chk("ill_err", err, 1);
    chk("ill_ctl_c2", {bank_en, bank_clr, bank_pre}, 0);

    // All four PRESET held: rotation from ptr=0
    req = 4'hF; op = 8'hAA;
    na = 0; ovl = 0;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) seq[i] = '0;
    for (int k = 0; k < 80 && na < 5; k++) begin
      @(negedge clk);
      if (bank_pre && bank_en) ovl++;
      if (bank_clr) ovl++;
      if (ack != 0) begin
        seq[na] = ack;
        na++;
        if (na == 5) req = '0;
      end
    end
    for (int i = 0; i < 5; i++) chk($sformatf("rr_ack%0d", i), seq[i], exp_seq[i]);
    chk("rr_overlap", ovl, 0);

    // CLEAR aborted by reset in HOLD
    @(negedge clk);
    req = 4'b0001; op = 8'h01;
    @(negedge clk);
    req = '0;
    chk("abort_clr_on", bank_clr, 1);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("abort_clr_off", bank_clr, 0);
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    clr = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack != 0) stray++;
    end
    chk("abort_noack", stray, 0);
    req = 4'b0001; op = 8'h00; d = 32'h0000_003C;
    @(negedge clk);
    req = '0;
    chk("post_rst_en", bank_en, 1);
    chk("post_rst_d", bank_d, 8'h3C);
    @(negedge clk);
    chk("post_rst_ack", ack, 4'b0001);
    chk("post_rst_err", err, 0);

    // Requesters 0 and 1 held, ptr reset to 0
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    req = 4'b0011; op = 8'h00;
`ifdef FF_OP_SCHED_PRIO_EN
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0001;
`else
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0010;
`endif
    na = 0;
    for (int i = 0; i < 5; i++) seq[i] = '0;
    for (int k = 0; k < 40 && na < 4; k++) begin
      @(negedge clk);
      if (ack != 0) begin
        seq[na] = ack;
        na++;
        if (na == 4) req = '0;
      end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("pair_ack%0d", i), seq[i], exp_seq[i]);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ff_op_sched.md
# ff_op_sched

Round-robin scheduler that shares one bank of asynchronously clearable/presettable flops between NREQ requesters. Each requester asks for a LOAD, CLEAR or PRESET operation. The block serialises the requests and drives the bank's enable, data, async-clear and async-preset lines with guaranteed pulse width and recovery time. It sits between the control agents and the flop bank, so no two agents ever drive the bank's control pins at once.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8
- WIDTH, 8: bank data width
- PULSE_CYC, 2: cycles bank_clr/bank_pre stay asserted, ≥1
- REC_CYC, 1: idle recovery cycles after clr/pre deassert before ack, ≥0

Ports:
- clk  in  1  clock, all logic on posedge
- clr  in  1  reset, asynchronous, active-low
- req  in  NREQ  request per requester, level
- op  in  2*NREQ  op for requester i at [2i+1:2i]: 00 LOAD, 01 CLEAR, 10 PRESET, 11 illegal
- d  in  WIDTH*NREQ  load data for requester i at [WIDTH*i +: WIDTH]
- ack  out  NREQ  one-hot, one-cycle completion pulse
- err  out  1  valid with ack; 1 = illegal op rejected
- busy  out  1  FSM not in IDLE
- gnt_id  out  $clog2(NREQ)  index of current/last granted requester
- bank_d  out  WIDTH  data to bank
- bank_en  out  1  bank load strobe
- bank_clr  out  1  bank async clear, active-high
- bank_pre  out  1  bank async preset, active-high

## Operation
- All outputs are registered. Reset value of every output and of the RR pointer is 0, and the FSM resets to IDLE.
- FSM states: IDLE, ISSUE, HOLD, RECOVER, DONE.
- IDLE: if any req is high, pick the winner by searching upward from ptr with wraparound. Latch its op and d, set gnt_id, set ptr = (winner+1) mod NREQ, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - LOAD: bank_en=1 and bank_d=latched d for exactly one cycle, then DONE.
  - CLEAR: set bank_clr=1, then go to HOLD.
  - PRESET: set bank_pre=1, then go to HOLD.
  - Illegal: no bank activity, err staged, then DONE.
- HOLD: keep bank_clr or bank_pre asserted for PULSE_CYC cycles in total, counting from ISSUE. Then deassert and go to RECOVER, or to DONE if REC_CYC=0.
- RECOVER: all bank controls stay 0 for REC_CYC cycles, then DONE.
- DONE: ack[gnt_id]=1 for one cycle, err per op, then IDLE.
- bank_clr and bank_pre are never high together. bank_en is never high while either of them is high.
- bank_d holds its last value outside LOAD.
- Op and data are sampled only at grant. Changes to req, op or d after grant have no effect on the running operation.
- A requester must drop req in the cycle after its ack; a req still high then is a new request.
- A requester that drops req before grant is simply not served.

## Timing
- The grant edge is T, when IDLE samples req.
- LOAD: bank_en is high in cycle T+1 and ack in cycle T+2. Throughput is one LOAD per 3 cycles.
- CLEAR/PRESET: control is high in cycles T+1 .. T+PULSE_CYC. RECOVER occupies the next REC_CYC cycles. ack comes at T+PULSE_CYC+REC_CYC+1. Defaults give ack at T+4.
- Illegal op: ack with err=1 at T+2.
- Simultaneous requests: one grant per IDLE visit. Back-to-back requests from different requesters are granted on the cycle after DONE.
- Fairness: with all req held, grants rotate 0,1,..,NREQ-1,0.
- Reset mid-operation: asserting clr forces bank_clr, bank_pre, bank_en and ack to 0 immediately (asynchronous) and aborts the op with no ack. After release, the FSM starts in IDLE with ptr=0.
- busy is high from T+1 through DONE inclusive.

## Configuration
- FF_OP_SCHED_PRIO_EN defined: requester 0 wins in IDLE whenever req[0]=1, regardless of ptr. ptr still advances to winner+1. Other requesters rotate round-robin among themselves.
- FF_OP_SCHED_PRIO_EN undefined: pure round-robin for all requesters, including 0.

## Test plan
- Reset, then req[2]=1 with op LOAD and d[2]=8'hA5. Required: bank_en=1 and bank_d=A5 in cycle T+1, ack=4'b0100 and err=0 in cycle T+2, and no bank_clr/bank_pre activity.
- req[1] with op CLEAR at defaults (PULSE_CYC=2, REC_CYC=1). Required: bank_clr high for exactly 2 cycles, 1 idle cycle, ack[1] at T+4, and busy high for 4 cycles.
- All four req held continuously with op PRESET. Required: ack order 0,1,2,3,0, and bank_pre never overlaps bank_en.
- req[3] with op=11. Required: ack[3]=1 and err=1 at T+2, and every bank control stays 0.
- Start a CLEAR, then pull clr low in the HOLD cycle. Required: bank_clr=0 in the same cycle (async), no ack. After release, req[0] with LOAD completes normally with ack at T+2.
- With FF_OP_SCHED_PRIO_EN, req[0] and req[1] held. Required: ack[0] on every grant and ack[1] never. Without the macro, they alternate 0,1,0,1.
